// File: rtl/mul12u_pkg.sv
// Shared definitions for the 12x12 unsigned approximate multiplier datapath:
// product width, accumulator stage state encoding and width helper.
package mul12u_pkg;

  localparam int PROD_W = 24;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

  // Sum of n_terms products of in_w bits can never exceed in_w + log2(n_terms) bits.
  function automatic int acc_width(input int in_w, input int n_terms);
    return in_w + $clog2(n_terms);
  endfunction

endpackage

// File: rtl/mul12u_acc_stage.sv
// Dot-product accumulator behind the approximate multiplier: sums up to N_TERMS
// products per run and presents the run total on a valid/ready hold register.
module mul12u_acc_stage
  import mul12u_pkg::*;
#(
  parameter int IN_W    = PROD_W,
  parameter int N_TERMS = 16,
  parameter int CNT_W   = $clog2(N_TERMS) + 1,
  parameter int ACC_W   = acc_width(IN_W, N_TERMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);

  acc_state_e       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_count;

  logic             w_accept;
  logic             w_close;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // NOTE: in_ready is the only combinational output; in HOLD it follows out_ready so a
  // draining result and the first term of the next run share one cycle with no bubble.
  assign in_ready  = (r_state == ACC) || out_ready;
  assign w_accept  = in_valid && in_ready;

  // acc/cnt are cleared at every run close, so in HOLD these start a fresh run.
  assign w_acc_nxt = r_acc + ACC_W'(in_prod);
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_close   = in_last || (w_cnt_nxt == CNT_W'(N_TERMS));

  // NOTE: all state uses non-blocking assignments so every register updates from the
  // same pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
    end else begin
      if (w_accept && w_close) begin
        r_out_sum   <= w_acc_nxt;
        r_out_count <= w_cnt_nxt;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_state     <= HOLD;
      end else begin
        if (w_accept) begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_nxt;
        end
        // Result taken by the sink and no new result reloads it: drop back to ACC.
        if (r_state == HOLD && out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= ACC;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_mul12u_acc_stage.sv
// Self-checking bench for mul12u_acc_stage: vector table, directed run sequences and
// randomized throttled traffic against a run-sum scoreboard model.
module tb_mul12u_acc_stage;

  localparam int IN_W    = 24;
  localparam int N_TERMS = 16;
  localparam int CNT_W   = 5;
  localparam int ACC_W   = 28;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  mul12u_acc_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard model: completed runs waiting for the sink, plus the open run.
  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
  } res_t;

  res_t             q[$];
  logic [ACC_W-1:0] m_sum;
  int               m_cnt;
  int               m_runs;

  task automatic model_reset();
    q.delete();
    m_sum = '0;
    m_cnt = 0;
  endtask

  // One clock: drive inputs, check/advance the model at negedge, return #1 after posedge.
  task automatic cycle(input logic v, input logic [IN_W-1:0] p, input logic l,
                       input logic ordy, output logic rdy_seen);
    logic exp_rdy;
    res_t r;
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = ordy;
    @(negedge clk);
    rdy_seen = in_ready;
    exp_rdy  = (q.size() == 0) || ordy;
    check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    if (q.size() != 0 && ordy) begin
      r = q.pop_front();
      check("out_sum", 32'(out_sum), 32'(r.sum));
      check("out_count", 32'(out_count), 32'(r.cnt));
    end
    if (v && exp_rdy) begin
      m_sum = m_sum + ACC_W'(p);
      m_cnt++;
      if (l || m_cnt == N_TERMS) begin
        q.push_back('{m_sum, CNT_W'(m_cnt)});
        m_runs++;
        m_sum = '0;
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_prod   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst out_sum", 32'(out_sum), 32'd0);
    check("rst out_count", 32'(out_count), 32'd0);
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic             v;
    logic [IN_W-1:0]  p;
    logic             l;
    logic             ordy;
    logic             exp_rdy;
    logic             exp_ov;
    logic             chk_data;
    logic [ACC_W-1:0] exp_sum;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic rdy;
    logic [ACC_W-1:0] held_sum;
    logic [CNT_W-1:0] held_cnt;
    int   guard;

    //        v   prod          l   ordy rdy  ov  chk  sum            cnt
    vecs[0]  = '{1, 24'h000040, 0, 1,   1,   0,  1,   28'h0,         5'd0};
    vecs[1]  = '{1, 24'h001000, 0, 1,   1,   0,  1,   28'h0,         5'd0};
    vecs[2]  = '{1, 24'h040000, 1, 1,   1,   1,  1,   28'h0041040,   5'd3};
    vecs[3]  = '{1, 24'h000123, 1, 1,   1,   1,  1,   28'h0000123,   5'd1};
    vecs[4]  = '{1, 24'hFFFFFF, 1, 1,   1,   1,  1,   28'h0FFFFFF,   5'd1};
    vecs[5]  = '{1, 24'h000005, 1, 1,   1,   1,  1,   28'h0000005,   5'd1};
    vecs[6]  = '{0, 24'h000000, 0, 1,   1,   0,  0,   28'h0,         5'd0};
    vecs[7]  = '{1, 24'h000007, 0, 0,   1,   0,  0,   28'h0,         5'd0};
    vecs[8]  = '{1, 24'h000009, 1, 0,   1,   1,  1,   28'h0000010,   5'd2};
    vecs[9]  = '{1, 24'h000064, 1, 0,   0,   1,  1,   28'h0000010,   5'd2};
    vecs[10] = '{0, 24'h000000, 1, 0,   0,   1,  1,   28'h0000010,   5'd2};
    vecs[11] = '{1, 24'h000003, 0, 1,   1,   0,  0,   28'h0,         5'd0};
    vecs[12] = '{0, 24'h000000, 1, 1,   1,   0,  0,   28'h0,         5'd0};
    vecs[13] = '{1, 24'h000004, 1, 1,   1,   1,  1,   28'h0000007,   5'd2};

    m_runs = 0;
    reset_dut();

    // Table: short run with early last, back-to-back single-term runs, held sink.
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].v, vecs[i].p, vecs[i].l, vecs[i].ordy, rdy);
      check($sformatf("vec%0d in_ready", i), {31'b0, rdy}, {31'b0, vecs[i].exp_rdy});
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_ov});
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d out_sum", i), 32'(out_sum), 32'(vecs[i].exp_sum));
        check($sformatf("vec%0d out_count", i), 32'(out_count), 32'(vecs[i].exp_cnt));
      end
    end

    // Full 16-term run closes on the count limit.
    reset_dut();
    for (int i = 0; i < N_TERMS - 1; i++) cycle(1'b1, 24'hC40000, 1'b0, 1'b1, rdy);
    check("full run early valid", {31'b0, out_valid}, 32'd0);
    cycle(1'b1, 24'hC40000, 1'b0, 1'b1, rdy);
    check("full run valid", {31'b0, out_valid}, 32'd1);
    check("full run sum", 32'(out_sum), 32'h0C400000);
    check("full run count", 32'(out_count), 32'd16);

    // Sink stalls 5 cycles: input blocked, result frozen; release starts next run at once.
    cycle(1'b1, 24'h000011, 1'b1, 1'b1, rdy);
    held_sum = out_sum;
    held_cnt = out_count;
    check("stall seed sum", 32'(held_sum), 32'h11);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 24'h000022, 1'b0, 1'b0, rdy);
      check("stall in_ready", {31'b0, rdy}, 32'd0);
      check("stall sum stable", 32'(out_sum), 32'(held_sum));
      check("stall count stable", 32'(out_count), 32'(held_cnt));
      check("stall valid stable", {31'b0, out_valid}, 32'd1);
    end
    cycle(1'b1, 24'h000022, 1'b0, 1'b1, rdy);
    check("release in_ready", {31'b0, rdy}, 32'd1);
    cycle(1'b1, 24'h000033, 1'b1, 1'b1, rdy);
    check("release run sum", 32'(out_sum), 32'h55);
    check("release run count", 32'(out_count), 32'd2);
    cycle(1'b0, '0, 1'b0, 1'b1, rdy);

    // Reset mid-run discards the partial sum.
    for (int i = 0; i < 7; i++) cycle(1'b1, 24'h123456, 1'b0, 1'b1, rdy);
    reset_dut();
    for (int i = 0; i < N_TERMS; i++) cycle(1'b1, 24'h000001, 1'b0, 1'b1, rdy);
    check("post-reset sum", 32'(out_sum), 32'd16);
    check("post-reset count", 32'(out_count), 32'd16);
    cycle(1'b0, '0, 1'b0, 1'b1, rdy);

    // Randomized throttling with truncated-operand approximate products.
    m_runs = 0;
    guard  = 0;
    while (m_runs < 1000 && guard < 40000) begin
      logic [11:0] a, b;
      logic [IN_W-1:0] p;
      a = 12'($urandom_range(0, 4095));
      b = 12'($urandom_range(0, 4095));
      p = IN_W'(((a >> 9) << 9) * ((b >> 9) << 9));
      cycle($urandom_range(0, 3) != 0, p, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0, rdy);
      guard++;
    end
    check("random runs completed", 32'(m_runs >= 1000), 32'd1);
    guard = 0;
    while (q.size() != 0 && guard < 4) begin
      cycle(1'b0, '0, 1'b0, 1'b1, rdy);
      guard++;
    end
    check("scoreboard drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
